// File: rtl/frame_reader.sv
// Streams a stored 16-bit frame out of memory as high/low byte pairs over a
// valid/ready byte link, one outstanding memory read at a time.
module frame_reader #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int RD_LAT = 2
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iStart,
    output logic [19:0] oMemAddr,
    output logic        oMemRE,
    input  logic [15:0] iMemData,
    output logic [7:0]  oTxData,
    output logic        oTxValid,
    input  logic        iTxReady,
    output logic        oBusy,
    output logic        oDone
);
    localparam logic [19:0] LAST_ADDR = 20'(H_RES * V_RES - 1);
    localparam int          LW        = $clog2(RD_LAT + 1);
    localparam logic [LW-1:0] LAT_MAX = LW'(RD_LAT);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SEND_HI,
        SEND_LO,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [19:0]   addr_q, addr_d;
    logic          re_q, re_d;
    logic [7:0]    txd_q, txd_d;
    logic          txv_q, txv_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [7:0]    lo_q, lo_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          start_prev_q, start_prev_d;
    logic          start;

    assign start = iStart & ~start_prev_q;

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            re_q         <= 1'b0;
            txd_q        <= '0;
            txv_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            lo_q         <= '0;
            lat_q        <= '0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            re_q         <= re_d;
            txd_q        <= txd_d;
            txv_q        <= txv_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            lo_q         <= lo_d;
            lat_q        <= lat_d;
            start_prev_q <= start_prev_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        re_d         = 1'b0;
        txd_d        = txd_q;
        txv_d        = txv_q;
        busy_d       = busy_q;
        done_d       = done_q;
        lo_d         = lo_q;
        lat_d        = lat_q;
        start_prev_d = iStart;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = READ;
                    addr_d  = '0;
                    re_d    = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    lat_d   = LW'(1);
                end
            end
            READ: begin
                // lat_q counts edges since the read enable was registered
                if (lat_q == LAT_MAX) begin
                    lo_d    = iMemData[7:0];
                    txd_d   = iMemData[15:8];
                    txv_d   = 1'b1;
                    state_d = SEND_HI;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            SEND_HI: begin
                if (iTxReady) begin
                    txd_d   = lo_q;
                    state_d = SEND_LO;
                end
            end
            SEND_LO: begin
                if (iTxReady) begin
                    txv_d = 1'b0;
                    if (addr_q == LAST_ADDR) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + 20'd1;
                        re_d    = 1'b1;
                        lat_d   = LW'(1);
                        state_d = READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign oMemAddr = addr_q;
    assign oMemRE   = re_q;
    assign oTxData  = txd_q;
    assign oTxValid = txv_q;
    assign oBusy    = busy_q;
    assign oDone    = done_q;
endmodule

// File: doc/frame_reader.md
# frame_reader

Reads a stored 16-bit-per-pixel frame back out of frame memory, one word per pixel at addresses 0 to H_RES*V_RES-1, and streams each pixel as two bytes, high byte first, over a valid/ready byte interface toward the UART/PC transmitter. It is the read-side counterpart to the frame capture writer. It is started once the capture logic reports the frame ready, and it owns the memory read port for the duration of the transfer.

## Interface
- H_RES, 640, pixels per line in memory
- V_RES, 480, lines in memory
- RD_LAT, 2, memory read latency in cycles, min 1
- iCLK  in  1  system clock, same domain as the memory controller
- iRST_N  in  1  synchronous active-low reset, sampled on rising iCLK
- iStart  in  1  start request; a rising edge starts one frame transfer
- oMemAddr  out  20  memory read address
- oMemRE  out  1  memory read enable, one-cycle pulse per word
- iMemData  in  16  memory read data, valid RD_LAT cycles after oMemRE
- oTxData  out  8  byte to transmitter
- oTxValid  out  1  oTxData valid
- iTxReady  in  1  transmitter accepts the byte when iTxReady and oTxValid are both high at a rising edge
- oBusy  out  1  transfer in progress
- oDone  out  1  whole frame sent; sticky until the next start

## Operation
- Reset values: all registered outputs are 0 (oMemAddr, oMemRE, oTxData, oTxValid, oBusy, oDone). The state is IDLE, the word latch is 0, and the start-edge register is 0.
- Start detection:
  - A start is `iStart & ~iStart_d`, where `iStart_d` is the previous-cycle iStart.
  - Because `iStart_d` resets to 0, an iStart held high through reset release starts one transfer.
- States:
  - IDLE or DONE, on start: go to READ. Set oMemAddr=0, oMemRE=1, oBusy=1, oDone=0.
  - READ: oMemRE is high for exactly one cycle, then low. Count RD_LAT cycles from the cycle oMemRE was registered high. On the RD_LAT-th edge, latch iMemData, set oTxData=iMemData[15:8] and oTxValid=1, and go to SEND_HI.
  - SEND_HI: on handshake, set oTxData=word[7:0], keep oTxValid=1, and go to SEND_LO.
  - SEND_LO, on handshake:
    - If oMemAddr==H_RES*V_RES-1: set oTxValid=0, oBusy=0, oDone=1, and go to DONE.
    - Otherwise: set oTxValid=0, oMemAddr=oMemAddr+1, oMemRE=1, and go to READ.
- Handshake rules:
  - While oTxValid is high and not accepted, oTxData and oTxValid hold stable.
  - iTxReady is ignored while oTxValid is low.
- Start requests while in READ, SEND_HI or SEND_LO are ignored. There is no restart mid-frame.
- DONE holds oDone=1 and keeps oMemAddr at the last address. A new start edge restarts from address 0.
- Width rules:
  - Last address = H_RES*V_RES-1, computed at elaboration; it must fit in 20 bits (default 307199).
  - The address increment never wraps in normal operation.
- Reset mid-operation: on the next edge with iRST_N=0, every output returns to its reset value, including dropping oTxValid without a handshake. The partial frame is discarded.

## Timing
- Start edge sampled at edge k:
  - oMemRE=1 and oMemAddr=0 visible after edge k.
  - oMemRE drops after edge k+1.
  - iMemData sampled at edge k+RD_LAT.
  - oTxValid=1 with the high byte visible after edge k+RD_LAT.
- Per-pixel period with iTxReady tied high is RD_LAT+2 cycles:
  - High byte accepted at edge k+RD_LAT+1.
  - Low byte accepted at edge k+RD_LAT+2.
  - The next oMemRE is registered at that same edge.
- Full frame with iTxReady high: H_RES*V_RES*(RD_LAT+2) cycles from the start edge to oDone.
- oMemRE never overlaps an outstanding read: there is at most one read in flight.
- Backpressure stalls only the SEND states. The memory is never re-read for a stalled byte.

## Test plan
- Reset with H_RES=4, V_RES=2, RD_LAT=2, memory preloaded with 0x1000+addr, iStart low: all outputs 0 for 10 cycles. oMemRE never pulses.
- Start pulse, iTxReady=1:
  - Byte stream is 10 00 10 01 … 10 07 (16 bytes).
  - Exactly 8 oMemRE pulses, at addresses 0..7.
  - oDone rises 32 cycles after the start edge; oBusy falls on the same edge.
- Backpressure with iTxReady toggling on a random pattern (30% ready): same 16-byte sequence. oTxData and oTxValid are held stable on every non-accepted cycle. oMemRE count is still 8.
- Latency sweep RD_LAT=1 and RD_LAT=4: the first oTxValid appears exactly RD_LAT cycles after oMemRE. Byte data is correct for each setting.
- iStart pulsed again at pixel 3: ignored, stream unchanged.
- iStart held high from reset release: exactly one transfer runs. No second transfer starts until iStart goes low and then high. A second start from DONE replays 10 00… from address 0.
- iRST_N low during SEND_LO of pixel 5: the next edge shows all outputs 0 and the state IDLE. A following start produces a complete fresh frame from address 0.
